// File: rtl/muldiv_scheduler.sv
// Round-robin scheduler sharing one multi-cycle arithmetic unit between two requesters,
// with operand capture, start pulse, watchdog abort and a one-cycle response strobe.
module muldiv_scheduler #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req_op0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [7:0]       req_op1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             unit_start,
  output logic [7:0]       unit_op,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             unit_abort,
  input  logic             unit_done,
  input  logic [WIDTH-1:0] unit_result,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy,
  output logic             owner
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          last_grant;
  logic [1:0]    grant;
  logic          fire;
  logic          timed_out;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant = 2'b00;
    if (rstn && state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign fire      = |grant;
  assign timed_out = (count == '0);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fire) state_next = ISSUE;
      ISSUE:   state_next = BUSY;
      BUSY:    if (unit_done || timed_out) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    unit_start = (state == ISSUE);
    unit_abort = (state == BUSY) && !unit_done && timed_out;
    rsp_valid  = (state == RESP) ? {owner, ~owner} : 2'b00;
    busy       = (state != IDLE);
  end

  // Completion wins over the watchdog when both land in the same BUSY cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      unit_op    <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      owner      <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            owner   <= grant[1];
            unit_op <= grant[1] ? req_op1 : req_op0;
            unit_a  <= grant[1] ? req_a1  : req_a0;
            unit_b  <= grant[1] ? req_b1  : req_b0;
          end
        end
        ISSUE: count <= TIMEOUT_LOAD;
        BUSY: begin
          if (unit_done) begin
            rsp_result <= unit_result;
            rsp_err    <= 1'b0;
          end else if (timed_out) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end else begin
            count <= count - CW'(1);
          end
        end
        RESP: last_grant <= owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Self-checking bench for muldiv_scheduler: a transaction-timeline model predicts every
// output each cycle, while directed sections pin grant order, latency, timeout and reset.
module tb_muldiv_scheduler;

  localparam int WIDTH = 32;
  localparam int TO    = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [7:0]       req_op0, req_op1;
  logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
  logic             unit_start, unit_abort, unit_done;
  logic [7:0]       unit_op;
  logic [WIDTH-1:0] unit_a, unit_b, unit_result;
  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err, busy, owner;

  muldiv_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
    .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
    .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_abort(unit_abort), .unit_done(unit_done), .unit_result(unit_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit known = 0;

  // stimulus controls
  int mode = 0;
  bit rst_now = 0;
  bit rand_rst = 0;
  int stray_div = 0;

  // requesters
  bit         r_v   [2];
  logic [7:0] r_op  [2];
  logic [31:0] r_a  [2];
  logic [31:0] r_b  [2];
  bit g_prev = 0;
  bit g_prev_idx = 0;

  // planned unit behaviour: k = BUSY cycle in which done arrives (> TO+1 means never)
  int          plan_k_q   [$];
  logic [31:0] plan_res_q [$];
  bit          plan_fix_q [$];

  // transaction-level model
  bit          in_txn = 0;
  int          hs = 0;
  int          k = 0;
  logic [31:0] t_res;
  bit          t_own;
  logic [7:0]  t_op;
  logic [31:0] t_a, t_b;
  bit          last_grant = 1;
  bit          m_owner = 0;
  logic [7:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_rres = '0;
  bit          m_rerr = 0;

  // expectations for the current cycle
  logic [1:0]  e_ready, e_rvalid;
  logic        e_start, e_abort, e_busy, e_rerr, e_owner;
  logic [7:0]  e_op;
  logic [31:0] e_a, e_b, e_rres;

  // what the DUT was seen doing
  int          obs_hs      [$];
  bit          obs_gidx    [$];
  int          obs_start   [$];
  int          obs_abort   [$];
  int          obs_rsp_cyc [$];
  logic [1:0]  obs_rsp_v   [$];
  logic [31:0] obs_rsp_res [$];
  bit          obs_rsp_err [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic need(input string name, input int have, input int want, output bit ok);
    ok = (have >= want);
    checkOutput(name, 32'(ok), 32'd1);
  endtask

  task automatic new_ops(input int i);
    r_op[i] = 8'($urandom);
    r_a[i]  = $urandom;
    r_b[i]  = $urandom;
  endtask

  task automatic cycle_step();
    int p, kk;
    bit end_txn, real_done, in_win, want, g_this, g_idx;
    end_txn = 0;
    g_this  = 0;
    g_idx   = 0;

    for (int i = 0; i < 2; i++) begin
      case (mode)
        0:       want = 1;
        1:       want = ($urandom_range(0, 1) == 1);
        2:       want = (i == 0);
        3:       want = (i == 1);
        default: want = 0;
      endcase
      if (g_prev && int'(g_prev_idx) == i) begin
        r_v[i] = want;
        if (want) new_ops(i);
      end else if (!r_v[i]) begin
        r_v[i] = want;
        if (want) new_ops(i);
      end else if (mode == 1) begin
        if ($urandom_range(0, 15) == 0) r_v[i] = 0;
      end else if (!want) begin
        r_v[i] = 0;
      end
    end

    rstn = rst_now;
    if (rand_rst && $urandom_range(0, 249) == 0) rstn = 1'b0;

    p         = cyc - hs;
    kk        = (k < TO + 1) ? k : TO + 1;
    real_done = in_txn && (k <= TO + 1) && (p == 1 + k);
    in_win    = in_txn && (p >= 2) && (p <= 1 + kk);
    unit_done = real_done ||
                (!in_win && stray_div > 0 && $urandom_range(0, stray_div - 1) == 0);
    unit_result = real_done ? t_res : $urandom;

    e_ready  = 2'b00;
    e_start  = 0;
    e_abort  = 0;
    e_busy   = 0;
    e_rvalid = 2'b00;
    if (in_txn) begin
      e_busy  = 1;
      e_start = (p == 1);
      e_abort = (k > TO + 1) && (p == TO + 2);
      if (p == 1) begin
        m_owner = t_own; m_op = t_op; m_a = t_a; m_b = t_b;
      end
      if (p == 2 + kk) begin
        e_rvalid   = t_own ? 2'b10 : 2'b01;
        m_rres     = (k <= TO + 1) ? t_res : 32'd0;
        m_rerr     = (k > TO + 1);
        last_grant = t_own;
        end_txn    = 1;
      end
    end else if (rstn) begin
      case ({r_v[1], r_v[0]})
        2'b01:   e_ready = 2'b01;
        2'b10:   e_ready = 2'b10;
        2'b11:   e_ready = last_grant ? 2'b01 : 2'b10;
        default: e_ready = 2'b00;
      endcase
      if (e_ready != 2'b00) begin
        g_this = 1;
        g_idx  = e_ready[1];
        in_txn = 1;
        hs     = cyc;
        t_own  = g_idx;
        t_op   = r_op[g_idx];
        t_a    = r_a[g_idx];
        t_b    = r_b[g_idx];
        if (plan_k_q.size() > 0) begin
          k     = plan_k_q.pop_front();
          t_res = plan_res_q.pop_front();
          if (!plan_fix_q.pop_front()) t_res = $urandom;
        end else begin
          k     = $urandom_range(1, 8);
          t_res = $urandom;
        end
      end
    end

    e_owner = m_owner; e_op = m_op; e_a = m_a; e_b = m_b;
    e_rres  = m_rres;  e_rerr = m_rerr;

    if (end_txn) in_txn = 0;
    if (!rstn) begin
      in_txn = 0; last_grant = 1; known = 1; g_this = 0;
      m_owner = 0; m_op = '0; m_a = '0; m_b = '0; m_rres = '0; m_rerr = 0;
    end
    g_prev     = g_this;
    g_prev_idx = g_idx;

    req_valid = {r_v[1], r_v[0]};
    req_op0 = r_op[0]; req_a0 = r_a[0]; req_b0 = r_b[0];
    req_op1 = r_op[1]; req_a1 = r_a[1]; req_b1 = r_b[1];
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      cycle_step();
    end
  endtask

  task automatic drain();
    mode = 4;
    applyStimulus(2);
    for (int i = 0; i < 40; i++) begin
      if (!in_txn) break;
      applyStimulus(1);
    end
  endtask

  task automatic plan(input int pk, input logic [31:0] res, input bit fixed);
    plan_k_q.push_back(pk);
    plan_res_q.push_back(res);
    plan_fix_q.push_back(fixed);
  endtask

  // per-cycle comparison against the model, plus event logging
  always @(negedge clk) begin
    if (known && cyc >= 1) begin
      checkOutput("req_ready",  32'(req_ready),  32'(e_ready));
      checkOutput("unit_start", 32'(unit_start), 32'(e_start));
      checkOutput("unit_abort", 32'(unit_abort), 32'(e_abort));
      checkOutput("busy",       32'(busy),       32'(e_busy));
      checkOutput("rsp_valid",  32'(rsp_valid),  32'(e_rvalid));
      checkOutput("rsp_result", rsp_result,      e_rres);
      checkOutput("rsp_err",    32'(rsp_err),    32'(e_rerr));
      checkOutput("owner",      32'(owner),      32'(e_owner));
      checkOutput("unit_op",    32'(unit_op),    32'(e_op));
      checkOutput("unit_a",     unit_a,          e_a);
      checkOutput("unit_b",     unit_b,          e_b);
      if ((req_valid & req_ready) != 2'b00) begin
        obs_hs.push_back(cyc);
        obs_gidx.push_back(req_ready[1]);
      end
      if (unit_start) obs_start.push_back(cyc);
      if (unit_abort) obs_abort.push_back(cyc);
      if (rsp_valid != 2'b00) begin
        obs_rsp_cyc.push_back(cyc);
        obs_rsp_v.push_back(rsp_valid);
        obs_rsp_res.push_back(rsp_result);
        obs_rsp_err.push_back(rsp_err);
      end
    end
  end

  initial begin
    bit ok;
    int bh, br, ba;
    rstn = 1'b0; unit_done = 1'b0; unit_result = '0;
    r_v[0] = 1; r_v[1] = 1;
    r_op[0] = 8'h04; r_a[0] = 32'd100; r_b[0] = 32'd7;
    new_ops(1);

    // reset with both valid, then contention: first op done in 3rd BUSY cycle, rest in 1
    plan(3, 32'd14, 1);
    for (int i = 0; i < 4; i++) plan(1, 32'd0, 0);
    mode = 0; rst_now = 0;
    cycle_step();
    applyStimulus(1);
    rst_now = 1;
    applyStimulus(22);

    need("grant_count", obs_hs.size(), 5, ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) checkOutput("grant_order", 32'(obs_gidx[i]), 32'(i % 2));
      checkOutput("first_spacing", 32'(obs_hs[1] - obs_hs[0]), 32'd6);
      for (int i = 2; i < 5; i++) checkOutput("hs_spacing", 32'(obs_hs[i] - obs_hs[i-1]), 32'd4);
      need("start_count", obs_start.size(), 1, ok);
      if (ok) checkOutput("start_latency", 32'(obs_start[0] - obs_hs[0]), 32'd1);
      need("rsp_count", obs_rsp_cyc.size(), 2, ok);
      if (ok) begin
        checkOutput("single_latency", 32'(obs_rsp_cyc[0] - obs_hs[0]), 32'd5);
        checkOutput("single_valid",   32'(obs_rsp_v[0]), 32'd1);
        checkOutput("single_result",  obs_rsp_res[0], 32'd14);
        checkOutput("single_err",     32'(obs_rsp_err[0]), 32'd0);
        checkOutput("second_valid",   32'(obs_rsp_v[1]), 32'd2);
      end
    end

    // watchdog timeout on requester 1
    drain();
    bh = obs_hs.size(); br = obs_rsp_cyc.size(); ba = obs_abort.size();
    plan(99, 32'd0, 0);
    mode = 3; applyStimulus(1);
    mode = 4; applyStimulus(10);
    need("to_grant", obs_hs.size(), bh + 1, ok);
    if (ok) begin
      checkOutput("to_owner", 32'(obs_gidx[bh]), 32'd1);
      need("to_abort", obs_abort.size(), ba + 1, ok);
      if (ok) checkOutput("to_abort_cycle", 32'(obs_abort[ba] - obs_hs[bh]), 32'd6);
      need("to_rsp", obs_rsp_cyc.size(), br + 1, ok);
      if (ok) begin
        checkOutput("to_latency", 32'(obs_rsp_cyc[br] - obs_hs[bh]), 32'd7);
        checkOutput("to_valid",   32'(obs_rsp_v[br]), 32'd2);
        checkOutput("to_err",     32'(obs_rsp_err[br]), 32'd1);
        checkOutput("to_result",  obs_rsp_res[br], 32'd0);
      end
    end

    // done lands exactly on the counter==0 cycle, with stray dones around it
    drain();
    bh = obs_hs.size(); br = obs_rsp_cyc.size(); ba = obs_abort.size();
    plan(TO + 1, 32'hDEADBEEF, 1);
    stray_div = 2;
    mode = 2; applyStimulus(1);
    mode = 4; applyStimulus(10);
    stray_div = 0;
    checkOutput("tie_no_abort", 32'(obs_abort.size()), 32'(ba));
    need("tie_grant", obs_hs.size(), bh + 1, ok);
    if (ok) begin
      need("tie_rsp", obs_rsp_cyc.size(), br + 1, ok);
      if (ok) begin
        checkOutput("tie_latency", 32'(obs_rsp_cyc[br] - obs_hs[bh]), 32'd7);
        checkOutput("tie_valid",   32'(obs_rsp_v[br]), 32'd1);
        checkOutput("tie_result",  obs_rsp_res[br], 32'hDEADBEEF);
        checkOutput("tie_err",     32'(obs_rsp_err[br]), 32'd0);
      end
    end

    // reset while BUSY abandons the op; requester 0 wins the first tie afterwards
    drain();
    br = obs_rsp_cyc.size();
    plan(99, 32'd0, 0);
    mode = 0; applyStimulus(4);
    rst_now = 0; applyStimulus(1);
    rst_now = 1;
    bh = obs_hs.size();
    applyStimulus(1);
    @(negedge clk);
    #1;
    checkOutput("busy_after_reset", 32'(busy), 32'd0);
    checkOutput("no_rsp_after_reset", 32'(obs_rsp_cyc.size()), 32'(br));
    need("rst_regrant", obs_hs.size(), bh + 1, ok);
    if (ok) checkOutput("rst_first_owner", 32'(obs_gidx[bh]), 32'd0);
    applyStimulus(8);

    // randomized traffic with stray dones and occasional resets
    drain();
    mode = 1; rand_rst = 1; stray_div = 4;
    applyStimulus(3000);
    rand_rst = 0; stray_div = 0; rst_now = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
